id_emit: RTL and testbench
==========================

Name: id_emit

Overview:
- Transmit-side counterpart of the identifier recognizer (`id_fsm`).
- Converts a binary value into an identifier string and emits it one ASCII character per handshake: PREFIX, then the decimal digits MSD-first with leading zeros suppressed, then TERM.
- Used to generate character streams for the recognizer path and for the text-output channels.

Parameters:
- WIDTH, 8, bit width of the input value; derived localparam DIGITS = (WIDTH*3)/10 + 1 (8 gives 3).
- PREFIX, 8'h76 ("v"), first character of every identifier; must be a letter.
- TERM, 8'h20 (" "), delimiter emitted after the last digit.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- value  input  WIDTH  number to encode; captured when start is accepted
- ready  input  1  sink can accept char this cycle
- char  output  8  ASCII character
- valid  output  1  char is valid
- last  output  1  high with valid on the TERM character
- busy  output  1  high from start acceptance until TERM is transferred
- done  output  1  one-cycle pulse after the TERM transfer

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - char=8'h00, valid=0, last=0, busy=0, done=0.
  - BCD and shift registers cleared.
  - Takes effect immediately, including mid-stream; no partial output resumes after reset.
- All outputs are registered.
- A transfer occurs on a clock edge with valid=1 and ready=1.
- While valid=1 and ready=0: char, valid and last hold stable.
- States:
  - IDLE: start=1 at an edge → capture value, BCD=0, bit counter=WIDTH, busy=1, go to CONV. start in any other state is ignored.
  - CONV: double-dabble, one bit per cycle: add 3 to each BCD nibble ≥5, then shift in the value MSB. After exactly WIDTH cycles go to PFX, with char=PREFIX and valid=1 registered at that edge. First valid is WIDTH+1 cycles after the edge that sampled start.
  - PFX: on transfer, load char with the most significant nonzero BCD digit (or '0' if value=0) plus 8'h30, and go to DIG. The index of that digit is chosen combinationally; there are no skip cycles.
  - DIG: on transfer, if the current digit index is 0, load char=TERM and last=1, and go to TERM. Otherwise decrement the index and load the next digit + 8'h30. Inner and trailing zeros are emitted.
  - TERM: on transfer, valid=0, last=0, busy=0, done=1 for the next cycle only, then go to IDLE.
- With ready held high, the stream runs back to back: one character per cycle, no bubbles between PREFIX and TERM.
- done and a new start on the same edge: start is accepted if the state is IDLE at that edge (the cycle after TERM transfer).
- Max value (2^WIDTH - 1) fits in DIGITS nibbles with no overflow; BCD register width = 4*DIGITS.
- The emitted stream is always a valid identifier followed by a non-identifier delimiter.

Test Plan:
- WIDTH=8, value=0, ready=1 → exactly 3 transfers "v","0"," "; last only on " "; done one cycle after the " " transfer; busy low thereafter.
- value=5, start pulsed at edge T, ready=1 → valid first high at T+9 with char 8'h76; then "5", " " on consecutive cycles; done at T+12.
- value=255 → "v255 "; value=100 → "v100 " (zeros not suppressed after the first significant digit); value=9 → "v9 ".
- value=100 with ready toggled 1,0,0,1,0,1,… → char/valid/last unchanged during ready=0 cycles; sequence still "v100 "; no duplicated or dropped characters.
- start re-pulsed with value=7 during CONV and during DIG of value=42 → ignored; output remains "v42 "; a start the cycle after done for value=7 produces "v7 ".
- rst_n pulled low asynchronously (between edges) during DIG of value=123 → valid/busy/char drop to 0 immediately; after release a start with value=6 yields "v6 ". Loopback into `id_fsm`: its out matches an identifier on every emitted stream.

Source files
------------

// File: rtl/id_emit.sv
// id_emit: binary value to identifier character stream.
// Emits PREFIX, decimal digits MSD-first, then TERM.
module id_emit #(
  parameter int          WIDTH  = 8,
  parameter logic [7:0]  PREFIX = 8'h76,
  parameter logic [7:0]  TERM   = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             ready,
  output logic [7:0]       char,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int DIGITS = (WIDTH * 3) / 10 + 1;
  localparam int BW     = 4 * DIGITS;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW     = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_PFX,
    S_DIG,
    S_TRM
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BW-1:0]    adj;
  logic [IW-1:0]    msd;
  logic             xfer;

  assign xfer  = valid_q & ready;
  assign char  = char_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;

  function automatic logic [7:0] ascii(
    input logic [BW-1:0] b,
    input logic [IW-1:0] k
  );
    ascii = 8'h30;
    for (int i = 0; i < DIGITS; i++)
      if (k == IW'(i))
        ascii = {4'h0, b[4*i +: 4]} + 8'h30;
  endfunction

  // Double-dabble correction: add 3 to every nibble >= 5
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Index of most significant nonzero digit (0 when value is 0)
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] != 4'h0)
        msd = IW'(i);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = value;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == '0) begin
          char_d  = PREFIX;
          valid_d = 1'b1;
          state_d = S_PFX;
        end else begin
          bcd_d = {adj[BW-2:0], sh_q[WIDTH-1]};
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PFX: begin
        if (xfer) begin
          idx_d   = msd;
          char_d  = ascii(bcd_q, msd);
          state_d = S_DIG;
        end
      end
      S_DIG: begin
        if (xfer) begin
          if (idx_q == '0) begin
            char_d  = TERM;
            last_d  = 1'b1;
            state_d = S_TRM;
          end else begin
            idx_d  = idx_q - 1'b1;
            char_d = ascii(bcd_q, idx_q - 1'b1);
          end
        end
      end
      S_TRM: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_id_emit.sv
// tb_id_emit: randomized check of id_emit against
// a decimal-string reference model.
module tb_id_emit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] value;
  logic         ready;
  logic [7:0]   char;
  logic         valid;
  logic         last;
  logic         busy;
  logic         done;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] expq[$];
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  id_emit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .ready (ready),
    .char  (char),
    .valid (valid),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] req
  );
    ntests++;
    if (obs !== req) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, req);
    end
  endtask

  // Reference: "v" + decimal text + " "
  task automatic model(input int v);
    int t;
    logic [7:0] d[$];
    expq = {};
    expq.push_back(8'h76);
    t = v;
    if (t == 0) d.push_back(8'h30);
    while (t > 0) begin
      d.push_front(8'(8'h30 + t % 10));
      t = t / 10;
    end
    foreach (d[i]) expq.push_back(d[i]);
    expq.push_back(8'h20);
  endtask

  task automatic emit(
    input int v,
    input int mode,
    input bit inj,
    input bit chain
  );
    logic [7:0] got[$];
    bit         lst[$];
    int         cyc, first, ph;
    bit         r, hold, wl, fin;
    logic [7:0] hc;
    logic       hv, hl;
    model(v);
    start = 1'b1;
    value = W'(v);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on", busy, 1);
    cyc = 0; first = -1; ph = 0; fin = 0;
    while (!fin && cyc < 400) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = pat[ph % 6] != 0;
      else r = $urandom_range(0, 1) != 0;
      ph++;
      ready = r;
      if (inj && (cyc == 3 || cyc == W + 3)) begin
        start = 1'b1;
        value = W'(7);
      end else begin
        start = 1'b0;
      end
      wl = 0;
      if (valid && r) begin
        got.push_back(char);
        lst.push_back(last);
        wl = last;
      end
      hold = valid && !r;
      hc = char; hv = valid; hl = last;
      @(posedge clk); #1;
      cyc++;
      if (first < 0 && valid) first = cyc;
      if (hold) begin
        chk("hold_char", char, hc);
        chk("hold_valid", valid, hv);
        chk("hold_last", last, hl);
      end
      if (wl) begin
        chk("done", done, 1);
        chk("busy_off", busy, 0);
        chk("valid_off", valid, 0);
        if (mode == 0)
          chk("done_cyc", cyc, W + 1 + expq.size());
        fin = 1;
      end else if (done) begin
        chk("done_early", done, 0);
      end
    end
    start = 1'b0;
    chk("finished", fin, 1);
    chk("first_valid", first, W + 1);
    chk("len", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < got.size()) begin
        chk("char", got[i], expq[i]);
        chk("last", lst[i], i == expq.size() - 1);
      end
    end
    if (!chain) begin
      ready = 1'b1;
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    value = '0;
    ready = 1'b0;
    #12;
    chk("rst_char", char, 0);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    emit(0, 0, 0, 0);
    emit(5, 0, 0, 0);
    emit(255, 0, 0, 0);
    emit(100, 0, 0, 0);
    emit(9, 0, 0, 0);
    emit(100, 1, 0, 0);
    emit(42, 0, 1, 1);
    emit(7, 0, 0, 0);

    // Async reset in the middle of the digits of 123
    ready = 1'b1;
    start = 1'b1;
    value = W'(123);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    chk("pre_rst_valid", valid, 1);
    chk("pre_rst_char", char, 8'h32);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_char", char, 0);
    chk("mid_rst_last", last, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", valid, 0);
    emit(6, 0, 0, 0);

    for (int k = 0; k < 20; k++)
      emit(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
